tap_gesture_decoder: RTL

TAP_GESTURE_DECODER -- requirements
Module: tap_gesture_decoder

---
 rtl/tap_pkg.sv | 18 +
 rtl/tap_channel.sv | 152 +++++++++++++++
 rtl/tap_gesture_decoder.sv | 38 +++
 3 files changed

// File: rtl/tap_pkg.sv
// Shared types and constants for the tap gesture decoder.
// Holds the channel state encoding and gesture code values.
package tap_pkg;

    localparam int GEST_W = 3;

    localparam logic [GEST_W-1:0] GEST_NONE = 3'd0;
    localparam logic [GEST_W-1:0] GEST_ONE  = 3'd1;
    localparam logic [GEST_W-1:0] GEST_LONG = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        GAP     = 2'd2,
        LONG    = 2'd3
    } tap_state_e;

endpackage

// File: rtl/tap_channel.sv
// One tap channel: 2-flop synchroniser, edge detect, tap/gap FSM.
// Ports: clk_1k, rstn (async low), tap_in, window_ms, hold_ms in;
// gest_valid (1-cycle pulse), gest_code, busy out.
// Long press is built only when TAP_LONG_PRESS_EN is defined.
module tap_channel
    import tap_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_TAPS = 3
) (
    input  logic              clk_1k,
    input  logic              rstn,
    input  logic              tap_in,
    input  logic [CNT_W-1:0]  window_ms,
    input  logic [CNT_W-1:0]  hold_ms,
    output logic              gest_valid,
    output logic [GEST_W-1:0] gest_code,
    output logic              busy
);

    localparam logic [GEST_W-1:0] MAX_C = GEST_W'(MAX_TAPS);

    tap_state_e        state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [1:0]        arm_q, arm_d;
    logic [GEST_W-1:0] tap_cnt_q, tap_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [GEST_W-1:0] code_q, code_d;

    logic              armed, rise, fall, win_hit;
    logic [CNT_W:0]    cnt_p1;
    logic [CNT_W-1:0]  cnt_inc;
    logic [GEST_W-1:0] tap_sat;

    // Edges are masked until the synchroniser has filled after reset,
    // so a level already high at reset release is never a tap.
    assign armed   = (arm_q == 2'd3);
    assign rise    = armed & sync_q[1] & ~prev_q;
    assign fall    = armed & ~sync_q[1] & prev_q;

    // Compare in CNT_W+1 bits so counter+1 never wraps; a window of 0
    // is always hit on the first gap cycle, same as a window of 1.
    assign cnt_p1  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign win_hit = cnt_p1 >= {1'b0, window_ms};
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_p1[CNT_W-1:0];
    assign tap_sat = (tap_cnt_q >= MAX_C) ? tap_cnt_q
                                          : tap_cnt_q + GEST_ONE;

`ifdef TAP_LONG_PRESS_EN
    logic hold_hit;
    assign hold_hit = (hold_ms != '0) && (tap_cnt_q == GEST_ONE)
                      && (cnt_p1 >= {1'b0, hold_ms});
`else
    logic unused_hold;
    assign unused_hold = ^hold_ms;
`endif

    always_comb begin
        sync_d = {sync_q[0], tap_in};
        prev_d = sync_q[1];
        arm_d  = armed ? arm_q : arm_q + 2'd1;
    end

    always_ff @(posedge clk_1k or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_1k or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            arm_q     <= '0;
            tap_cnt_q <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            code_q    <= GEST_NONE;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            arm_q     <= arm_d;
            tap_cnt_q <= tap_cnt_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tap_cnt_d = tap_cnt_q;
        cnt_d     = cnt_inc;
        valid_d   = 1'b0;
        code_d    = code_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d   = PRESSED;
                    tap_cnt_d = GEST_ONE;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
`ifdef TAP_LONG_PRESS_EN
                else if (hold_hit) begin
                    state_d = LONG;
                    valid_d = 1'b1;
                    code_d  = GEST_LONG;
                end
`endif
            end
            GAP: begin
                // A rise on the expiry cycle wins: it is one more tap.
                if (rise) begin
                    state_d   = PRESSED;
                    tap_cnt_d = tap_sat;
                    cnt_d     = '0;
                end else if (win_hit) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    code_d  = tap_cnt_q;
                end
            end
`ifdef TAP_LONG_PRESS_EN
            LONG: begin
                if (fall) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        gest_valid = valid_q;
        gest_code  = code_q;
    end

endmodule

// File: rtl/tap_gesture_decoder.sv
// Multi-channel tap gesture decoder: NUM_CH independent tap_channel
// instances. Ports: clk_1k, rstn, tap_in, window_ms, hold_ms in;
// gest_valid, gest_code (3 bits per channel), busy out.
// Define TAP_LONG_PRESS_EN to build long-press detection.
module tap_gesture_decoder
    import tap_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int MAX_TAPS = 3
) (
    input  logic                     clk_1k,
    input  logic                     rstn,
    input  logic [NUM_CH-1:0]        tap_in,
    input  logic [CNT_W-1:0]         window_ms,
    input  logic [CNT_W-1:0]         hold_ms,
    output logic [NUM_CH-1:0]        gest_valid,
    output logic [NUM_CH*GEST_W-1:0] gest_code,
    output logic [NUM_CH-1:0]        busy
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tap_channel #(
            .CNT_W    (CNT_W),
            .MAX_TAPS (MAX_TAPS)
        ) u_ch (
            .clk_1k     (clk_1k),
            .rstn       (rstn),
            .tap_in     (tap_in[i]),
            .window_ms  (window_ms),
            .hold_ms    (hold_ms),
            .gest_valid (gest_valid[i]),
            .gest_code  (gest_code[i*GEST_W +: GEST_W]),
            .busy       (busy[i])
        );
    end

endmodule
